// File: rtl/instruction_fetch_if.sv
// Fetch-side bus bundle: icache lookup, redirect input, and the decode handshake.
// The master modport is the fetch unit; the slave modport is the surrounding core/testbench.
interface instruction_fetch_if #(
  parameter int addr_wid  = 64,
  parameter int instr_wid = 32
);
  logic                 load_busy_i;
  logic [addr_wid-1:0]  icache_addr_o;
  logic [instr_wid-1:0] icache_instr_i;
  logic                 redirect_i;
  logic [addr_wid-1:0]  redirect_pc_i;
  logic                 instr_valid_o;
  logic                 instr_ready_i;
  logic [instr_wid-1:0] instr_o;
  logic [addr_wid-1:0]  pc_o;
  logic                 misaligned_o;
  logic [31:0]          fetch_count_o;

  modport master (
    input  load_busy_i, icache_instr_i, redirect_i, redirect_pc_i, instr_ready_i,
    output icache_addr_o, instr_valid_o, instr_o, pc_o, misaligned_o, fetch_count_o
  );

  modport slave (
    output load_busy_i, icache_instr_i, redirect_i, redirect_pc_i, instr_ready_i,
    input  icache_addr_o, instr_valid_o, instr_o, pc_o, misaligned_o, fetch_count_o
  );
endinterface

// File: rtl/instruction_fetch.sv
// Single-entry instruction fetch stage: sequential PC, redirect, icache-load stall and
// misaligned-target fault. It holds one registered instruction for the decode handshake.
module instruction_fetch #(
  parameter int                  addr_wid  = 64,
  parameter int                  instr_wid = 32,
  parameter logic [addr_wid-1:0] reset_pc  = '0
) (
  input logic                 clk_i,
  input logic                 rst_i,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [addr_wid-1:0]  fetch_pc_q, fetch_pc_d;
  logic [addr_wid-1:0]  pc_q, pc_d;
  logic [instr_wid-1:0] instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 mis_q, mis_d;
  logic [31:0]          count_q, count_d;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    count_d    = count_q;

    if (bus.redirect_i) begin
      // Any redirect drops the held instruction; an in-flight handshake is simply consumed.
      valid_d = 1'b0;
      if (bus.redirect_pc_i[1:0] == 2'b00) begin
        fetch_pc_d = bus.redirect_pc_i;
        state_d    = (state_q == HALT) ? HALT : RUN;
      end else begin
        state_d = FAULT;
      end
    end else if (bus.load_busy_i) begin
      if (state_q == RUN) begin
        state_d = HALT;
        valid_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        HALT: begin
          state_d = RUN;
          valid_d = 1'b0;
        end
        RUN: begin
          if (!valid_q || bus.instr_ready_i) begin
            instr_d    = bus.icache_instr_i;
            pc_d       = fetch_pc_q;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + addr_wid'(4);
            count_d    = count_q + 32'd1;
          end
        end
        FAULT: valid_d = 1'b0;
        default: begin
          state_d = HALT;
          valid_d = 1'b0;
        end
      endcase
    end

    mis_d = (state_d == FAULT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= HALT;
      fetch_pc_q <= reset_pc;
      pc_q       <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      mis_q      <= mis_d;
      count_q    <= count_d;
    end
  end

  assign bus.icache_addr_o = fetch_pc_q;
  assign bus.instr_valid_o = valid_q;
  assign bus.instr_o       = instr_q;
  assign bus.pc_o          = pc_q;
  assign bus.misaligned_o  = mis_q;
  assign bus.fetch_count_o = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table walks run/stall/redirect/fault/halt,
// then hand sequences cover async reset mid-stream, redirect while halted and PC wrap.
module tb_instruction_fetch;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  instruction_fetch_if #(.addr_wid(64), .instr_wid(32)) bus ();

  instruction_fetch #(.addr_wid(64), .instr_wid(32), .reset_pc(64'h0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache model: word k holds 0x1000 + k.
  always_comb bus.icache_instr_i = 32'h1000 + 32'(bus.icache_addr_o >> 2);

  typedef struct {
    logic        busy;
    logic        red;
    logic [63:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    logic [63:0] e_addr;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [31:0] ins,
                         input logic [63:0] pc, input logic [63:0] addr, input logic mis,
                         input logic [31:0] cnt);
    chk({tag, ".valid"}, 64'(bus.instr_valid_o), 64'(v));
    chk({tag, ".instr"}, 64'(bus.instr_o), 64'(ins));
    chk({tag, ".pc"}, bus.pc_o, pc);
    chk({tag, ".addr"}, bus.icache_addr_o, addr);
    chk({tag, ".mis"}, 64'(bus.misaligned_o), 64'(mis));
    chk({tag, ".cnt"}, 64'(bus.fetch_count_o), 64'(cnt));
  endtask

  task automatic drive(input logic busy, input logic red, input logic [63:0] rpc, input logic rdy);
    bus.load_busy_i   = busy;
    bus.redirect_i    = red;
    bus.redirect_pc_i = rpc;
    bus.instr_ready_i = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //          busy red rpc           rdy  v  instr      pc      addr    mis cnt
    tbl[0]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 32'h0,    64'h0,  64'h0,  1'b0, 32'd0}; // HALT->RUN
    tbl[1]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 32'h1000, 64'h0,  64'h4,  1'b0, 32'd1};
    tbl[2]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 32'h1001, 64'h4,  64'h8,  1'b0, 32'd2};
    tbl[3]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 32'h1001, 64'h4,  64'h8,  1'b0, 32'd2}; // stall x3
    tbl[4]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 32'h1001, 64'h4,  64'h8,  1'b0, 32'd2};
    tbl[5]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 32'h1001, 64'h4,  64'h8,  1'b0, 32'd2};
    tbl[6]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 32'h1002, 64'h8,  64'hC,  1'b0, 32'd3};
    tbl[7]  = '{1'b0, 1'b1, 64'h40, 1'b1, 1'b0, 32'h1002, 64'h8,  64'h40, 1'b0, 32'd3}; // redirect
    tbl[8]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 32'h1010, 64'h40, 64'h44, 1'b0, 32'd4};
    tbl[9]  = '{1'b0, 1'b1, 64'h42, 1'b1, 1'b0, 32'h1010, 64'h40, 64'h44, 1'b1, 32'd4}; // fault
    tbl[10] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 32'h1010, 64'h40, 64'h44, 1'b1, 32'd4};
    tbl[11] = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b0, 32'h1010, 64'h40, 64'h44, 1'b1, 32'd4};
    tbl[12] = '{1'b0, 1'b1, 64'h80, 1'b1, 1'b0, 32'h1010, 64'h40, 64'h80, 1'b0, 32'd4}; // recover
    tbl[13] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 32'h1020, 64'h80, 64'h84, 1'b0, 32'd5};
    tbl[14] = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b0, 32'h1020, 64'h80, 64'h84, 1'b0, 32'd5}; // busy x5
    tbl[15] = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b0, 32'h1020, 64'h80, 64'h84, 1'b0, 32'd5};
    tbl[16] = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b0, 32'h1020, 64'h80, 64'h84, 1'b0, 32'd5};
    tbl[17] = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b0, 32'h1020, 64'h80, 64'h84, 1'b0, 32'd5};
    tbl[18] = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b0, 32'h1020, 64'h80, 64'h84, 1'b0, 32'd5};
    tbl[19] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 32'h1020, 64'h80, 64'h84, 1'b0, 32'd5}; // HALT->RUN
    tbl[20] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 32'h1021, 64'h84, 64'h88, 1'b0, 32'd6};
    tbl[21] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 32'h1022, 64'h88, 64'h8C, 1'b0, 32'd7};
    tbl[22] = '{1'b0, 1'b1, 64'h1C, 1'b1, 1'b0, 32'h1022, 64'h88, 64'h1C, 1'b0, 32'd7};
    tbl[23] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 32'h1007, 64'h1C, 64'h20, 1'b0, 32'd8};

    rst = 1'b1;
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    #2;
    chk_all("reset", 1'b0, 32'h0, 64'h0, 64'h0, 1'b0, 32'd0);
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].busy, tbl[i].red, tbl[i].rpc, tbl[i].rdy);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_instr, tbl[i].e_pc,
              tbl[i].e_addr, tbl[i].e_mis, tbl[i].e_cnt);
    end

    // Async reset between edges with fetch_pc=0x20, count=8 and a valid instruction held.
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, 64'h0, 64'h0, 1'b0, 32'd0);
    #1;
    rst = 1'b0;

    // Aligned redirect while halted: stays halted, then one RUN cycle, then capture.
    drive(1'b0, 1'b1, 64'h100, 1'b1);
    step();
    chk_all("halt_red", 1'b0, 32'h0, 64'h0, 64'h100, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    step();
    chk_all("halt_run", 1'b0, 32'h0, 64'h0, 64'h100, 1'b0, 32'd0);
    step();
    chk_all("halt_cap", 1'b1, 32'h1040, 64'h100, 64'h104, 1'b0, 32'd1);

    // Fetch PC wraps modulo 2^64.
    drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    step();
    chk_all("wrap_red", 1'b0, 32'h1040, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'd1);
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    step();
    chk_all("wrap_cap", 1'b1, 32'h0000_0FFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0, 32'd2);
    step();
    chk_all("wrap_next", 1'b1, 32'h1000, 64'h0, 64'h4, 1'b0, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter addr_wid, default 64, width of all program-counter and address signals.
REQ-002 SHALL have parameter instr_wid, default 32, width of an instruction word.
REQ-003 SHALL have parameter reset_pc, default 0, first fetch address after reset.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port load_busy_i  input  1  instruction cache being written; fetch suspended while high.
REQ-007 SHALL have port icache_addr_o  output  addr_wid  byte address presented to instruction cache.
REQ-008 SHALL have port icache_instr_i  input  instr_wid  instruction returned combinationally for icache_addr_o.
REQ-009 SHALL have port redirect_i  input  1  branch/jump taken; load redirect_pc_i.
REQ-010 SHALL have port redirect_pc_i  input  addr_wid  redirect target byte address.
REQ-011 SHALL have port instr_valid_o  output  1  instr_o/pc_o hold a fetched instruction.
REQ-012 SHALL have port instr_ready_i  input  1  decode accepts instruction this cycle.
REQ-013 SHALL have port instr_o  output  instr_wid  fetched instruction (registered).
REQ-014 SHALL have port pc_o  output  addr_wid  address of instr_o (registered).
REQ-015 SHALL have port misaligned_o  output  1  high while in FAULT.
REQ-016 SHALL have port fetch_count_o  output  32  number of captured instructions, wraps modulo 2^32.

Function
REQ-017 SHALL implement states HALT, RUN, FAULT; icache_addr_o equals internal fetch_pc at all times.
REQ-018 Capture: in RUN with load_busy_i=0 and redirect_i=0, when instr_valid_o=0 or (instr_valid_o & instr_ready_i), SHALL register instr_o<=icache_instr_i, pc_o<=fetch_pc, instr_valid_o<=1, fetch_pc<=fetch_pc+4 (mod 2^addr_wid), fetch_count_o+=1.
REQ-019 Hold: instr_valid_o=1 and instr_ready_i=0 SHALL leave instr_o, pc_o, fetch_pc, fetch_count_o unchanged.
REQ-020 Handshake complete (valid & ready) with no new capture SHALL clear instr_valid_o next cycle.
REQ-021 Priority per cycle SHALL be: rst_i > redirect_i > load_busy_i > capture.
REQ-022 redirect_i with redirect_pc_i[1:0]=0 SHALL set fetch_pc<=redirect_pc_i, clear instr_valid_o (current handshake still counts as consumed), no capture that cycle; RUN/FAULT->RUN, HALT stays HALT.
REQ-023 redirect_i with redirect_pc_i[1:0]!=0 SHALL enter FAULT, clear instr_valid_o, leave fetch_pc unchanged.
REQ-024 FAULT SHALL assert misaligned_o, perform no captures, exit only via reset or an aligned redirect (to RUN).
REQ-025 RUN with load_busy_i=1 SHALL go to HALT, clear instr_valid_o, hold fetch_pc.
REQ-026 HALT SHALL go to RUN on any cycle with load_busy_i=0 and redirect_i=0, with no capture in that cycle.
REQ-027 Sustained throughput SHALL be one instruction per cycle while instr_ready_i=1 in RUN.
REQ-028 Capture latency SHALL be 1 cycle: instruction at icache_addr_o in cycle N appears on instr_o in cycle N+1.

Reset
REQ-029 rst_i high SHALL immediately force state=HALT, fetch_pc=reset_pc, instr_valid_o=0, instr_o=0, pc_o=0, misaligned_o=0, fetch_count_o=0, including mid-handshake or in FAULT.
REQ-030 After rst_i release with load_busy_i=0, first edge SHALL enter RUN, second edge SHALL capture address reset_pc.

Verification
REQ-031 Reset release, load_busy_i=0, ready=1, cache word k = 0x1000+k -> edge2 instr_o=0x1000, pc_o=0; edge3 0x1001, pc_o=4; fetch_count_o=2.
REQ-032 Valid with ready=0 for 3 cycles -> instr_o, pc_o, fetch_pc, count frozen; ready=1 -> next pc_o = previous+4, no instruction lost or duplicated.
REQ-033 redirect_i with redirect_pc_i=0x40 while valid & ready -> next cycle valid=0, icache_addr_o=0x40; following cycle pc_o=0x40.
REQ-034 redirect_pc_i=0x42 -> misaligned_o=1, valid=0 persists; redirect 0x80 -> misaligned_o=0, next capture pc_o=0x80.
REQ-035 load_busy_i=1 for 5 cycles in RUN -> valid=0, fetch_pc held; deassert -> one HALT->RUN cycle then capture resumes at held pc.
REQ-036 rst_i asserted mid-stream at fetch_pc=0x20, count=8 -> all outputs at reset values same cycle without clock edge.
